// File: rtl/vs_sci_reader.sv
// vs_sci_reader: SCI register read controller for a VS10xx decoder.
// Issues SCI READ (opcode 0x03) frames on the shared XCS/SCK/SI pins after a
// request/grant handshake and captures the 16-bit reply from SO. It also
// re-reads POLL_ADDR (SCI_DECODE_TIME) every POLL_DIV cycles while poll_en=1.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset (applied on negedge)
//   start, addr       one-cycle read request and its register address
//   poll_en           enable automatic polling of POLL_ADDR
//   busy, done, err   status: in transaction / read complete / DREQ timeout
//   rdata             last value read
//   decode_time       last value read from POLL_ADDR
//   bus_req, bus_gnt  handshake with the write driver for the shared pins
//   DREQ, SO          decoder ready and serial data out
//   XCS, SCK, SI      SCI chip select (active low), serial clock, serial data
module vs_sci_reader #(
  parameter logic [31:0] POLL_DIV     = 32'd12288,
  parameter logic [7:0]  POLL_ADDR    = 8'h04,
  parameter logic [31:0] DREQ_TIMEOUT = 32'd65535,
  parameter logic [7:0]  GAP          = 8'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  addr,
  input  logic        poll_en,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] rdata,
  output logic [15:0] decode_time,
  output logic        bus_req,
  input  logic        bus_gnt,
  input  logic        DREQ,
  input  logic        SO,
  output logic        XCS,
  output logic        SCK,
  output logic        SI
);

  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned CNT_W      = 6;
  localparam logic [7:0]  SCI_READ   = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_DREQ,
    S_SHIFT,
    S_GAPW
  } state_t;

  state_t           state_q;
  logic [7:0]       addr_q;
  logic [31:0]      sreg_q;
  logic [CNT_W-1:0] bitcnt_q;
  logic [14:0]      rdata_sh_q;
  logic [31:0]      tcnt_q;
  logic [7:0]       gcnt_q;
  logic [31:0]      pcnt_q;
  logic             pending_q;
  logic             sck_en_q;
  logic             so_q;
  logic             poll_tick_c;
  logic             take_poll_c;

  // SCK is a gated copy of clk so each enabled period is exactly one pulse.
  assign SCK = clk & sck_en_q;

  assign poll_tick_c = poll_en && (pcnt_q == POLL_DIV - 32'd1);
  assign take_poll_c = (state_q == S_IDLE) && !start && pending_q;

  // SO is captured on the rising clk edge, i.e. on the rising SCK edge.
  always_ff @(posedge clk) begin
    if (!rst) so_q <= 1'b0;
    else      so_q <= SO;
  end

  // Poll interval counter; a tick raised while one is pending merges into it.
  always_ff @(negedge clk) begin
    if (!rst || !poll_en) begin
      pcnt_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      pcnt_q    <= poll_tick_c ? '0 : pcnt_q + 32'd1;
      pending_q <= poll_tick_c | (pending_q & ~take_poll_c);
    end
  end

  // Transaction sequencer with registered pin and status outputs.
  always_ff @(negedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      sreg_q      <= '0;
      bitcnt_q    <= '0;
      rdata_sh_q  <= '0;
      tcnt_q      <= '0;
      gcnt_q      <= '0;
      sck_en_q    <= 1'b0;
      XCS         <= 1'b1;
      SI          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      bus_req     <= 1'b0;
      rdata       <= '0;
      decode_time <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q  <= addr;
            busy    <= 1'b1;
            bus_req <= 1'b1;
            state_q <= S_REQ;
          end else if (pending_q) begin
            addr_q  <= POLL_ADDR;
            busy    <= 1'b1;
            bus_req <= 1'b1;
            state_q <= S_REQ;
          end
        end

        S_REQ: begin
          if (bus_gnt) begin
            tcnt_q  <= '0;
            state_q <= S_WAIT_DREQ;
          end
        end

        S_WAIT_DREQ: begin
          if (DREQ) begin
            sreg_q     <= {SCI_READ, addr_q, 16'h0000};
            bitcnt_q   <= CNT_W'(FRAME_BITS);
            rdata_sh_q <= '0;
            state_q    <= S_SHIFT;
          end else if (tcnt_q == DREQ_TIMEOUT - 32'd1) begin
            err     <= 1'b1;
            bus_req <= 1'b0;
            gcnt_q  <= '0;
            state_q <= S_GAPW;
          end else begin
            tcnt_q <= tcnt_q + 32'd1;
          end
        end

        S_SHIFT: begin
          if (bitcnt_q != '0) begin
            XCS      <= 1'b0;
            sck_en_q <= 1'b1;
            SI       <= sreg_q[31];
            sreg_q   <= {sreg_q[30:0], 1'b0};
            bitcnt_q <= bitcnt_q - CNT_W'(1);
            // This edge ends pulse 32-bitcnt; pulses 17..31 carry reply bits.
            if (bitcnt_q <= CNT_W'(15)) rdata_sh_q <= {rdata_sh_q[13:0], so_q};
          end else begin
            // Edge after pulse 32: its reply bit is still in so_q.
            XCS      <= 1'b1;
            sck_en_q <= 1'b0;
            SI       <= 1'b0;
            rdata    <= {rdata_sh_q, so_q};
            if (addr_q == POLL_ADDR) decode_time <= {rdata_sh_q, so_q};
            done     <= 1'b1;
            bus_req  <= 1'b0;
            gcnt_q   <= '0;
            state_q  <= S_GAPW;
          end
        end

        S_GAPW: begin
          if (gcnt_q == GAP - 8'd1) begin
            busy    <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            gcnt_q <= gcnt_q + 8'd1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vs_sci_reader.sv
// Bench for vs_sci_reader: decoder model on the SCI pins, a timeline model of
// the expected outputs checked every cycle, and directed scenarios with
// hand-computed literal expectations.
module tb_vs_sci_reader;

  localparam logic [31:0] P_DIV  = 32'd100;
  localparam logic [7:0]  P_ADDR = 8'h04;
  localparam logic [31:0] P_TO   = 32'd20;
  localparam logic [7:0]  P_GAP  = 8'd8;

  logic        clk, rst, start, poll_en, bus_gnt, DREQ, SO;
  logic [7:0]  addr;
  logic        busy, done, err, bus_req, XCS, SCK, SI;
  logic [15:0] rdata, decode_time;

  int n_cmp  = 0;
  int n_fail = 0;

  vs_sci_reader #(
    .POLL_DIV(P_DIV), .POLL_ADDR(P_ADDR), .DREQ_TIMEOUT(P_TO), .GAP(P_GAP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .poll_en(poll_en),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .decode_time(decode_time), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .DREQ(DREQ), .SO(SO), .XCS(XCS), .SCK(SCK), .SI(SI)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Register contents the decoder returns: SCI_DECODE_TIME counts up from 5.
  function automatic logic [15:0] resp_of(input logic [7:0] a, input int cnt4);
    if (a == 8'h04)      return 16'(cnt4);
    else if (a == 8'h0B) return 16'h2020;
    else                 return {a, 8'hA5};
  endfunction

  // ---------------- decoder model on the SCI pins ----------------
  int          dp = 0;
  int          d_cnt4 = 5;
  logic [15:0] dcmd = '0;
  logic [15:0] ddata = '0;
  logic [15:0] last_cmd = '0;

  always @(posedge SCK) begin
    dp = dp + 1;
    if (dp <= 16) dcmd = {dcmd[14:0], SI};
    if (dp == 16) begin
      last_cmd = dcmd;
      ddata = resp_of(dcmd[7:0], d_cnt4);
      if (dcmd[7:0] == 8'h04) d_cnt4++;
    end
  end

  always @(negedge SCK) begin
    if (dp >= 16 && dp <= 31) SO = ddata[31-dp];
  end

  always @(posedge XCS) dp = 0;

  // ---------------- timeline model of expected outputs ----------------
  // Each transaction is tracked by the falling-edge numbers at which it was
  // accepted, granted, saw DREQ and ended; pin values follow by arithmetic.
  bit          m_valid = 0;
  int          n = 0;
  int          acc_n = -1, gnt_n = -1, go_n = -1, end_n = -1;
  int          m_pc = 0, m_cnt4 = 5;
  bit          m_pend = 0, tick, shifting;
  logic [7:0]  m_addr = '0;
  logic [31:0] word;
  logic [15:0] e_rdata, e_dt, val;
  logic        e_busy, e_req, e_xcs, e_sck, e_si, e_done, e_err;

  always @(negedge clk) begin
    if (!rst) begin
      m_valid = 1; m_pc = 0; m_pend = 0;
      acc_n = -1; gnt_n = -1; go_n = -1; end_n = -1;
      e_rdata = '0; e_dt = '0; e_busy = 0; e_req = 0; e_xcs = 1;
      e_sck = 0; e_si = 0; e_done = 0; e_err = 0;
    end else if (m_valid) begin
      n++;
      tick = poll_en && (m_pc == int'(P_DIV) - 1);
      e_done = 0; e_err = 0;
      if (acc_n < 0) begin
        if (start) begin m_addr = addr; acc_n = n; end
        else if (m_pend) begin m_addr = P_ADDR; m_pend = 0; acc_n = n; end
        if (acc_n >= 0) begin gnt_n = -1; go_n = -1; end_n = -1; end
      end else if (gnt_n < 0) begin
        if (bus_gnt) gnt_n = n;
      end else if (go_n < 0 && end_n < 0) begin
        if (DREQ) go_n = n;
        else if (n - gnt_n == int'(P_TO)) begin end_n = n; e_err = 1; end
      end else if (end_n < 0) begin
        if (n == go_n + 33) begin
          end_n = n; e_done = 1;
          val = resp_of(m_addr, m_cnt4);
          if (m_addr == 8'h04) m_cnt4++;
          e_rdata = val;
          if (m_addr == P_ADDR) e_dt = val;
        end
      end else if (n == end_n + int'(P_GAP)) begin
        acc_n = -1;
      end
      m_pend = poll_en ? (m_pend || tick) : 1'b0;
      m_pc   = (!poll_en || tick) ? 0 : m_pc + 1;
      word     = {8'h03, m_addr, 16'h0000};
      shifting = (acc_n >= 0) && (go_n >= 0) && (end_n < 0) && (n > go_n);
      e_busy = acc_n >= 0;
      e_req  = (acc_n >= 0) && (end_n < 0);
      e_xcs  = !shifting;
      e_sck  = shifting;
      e_si   = shifting ? word[32-(n-go_n)] : 1'b0;
    end
  end

  // Per-cycle comparison, half a cycle after the falling (active) edge.
  always begin
    @(posedge clk);
    #1;
    if (m_valid) begin
      check("busy", 32'(busy), 32'(e_busy));
      check("bus_req", 32'(bus_req), 32'(e_req));
      check("XCS", 32'(XCS), 32'(e_xcs));
      check("SCK", 32'(SCK), 32'(e_sck));
      check("SI", 32'(SI), 32'(e_si));
      check("done", 32'(done), 32'(e_done));
      check("err", 32'(err), 32'(e_err));
      check("rdata", 32'(rdata), 32'(e_rdata));
      check("decode_time", 32'(decode_time), 32'(e_dt));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] a);
    start = 1'b1; addr = a;
    cyc();
    start = 1'b0;
  endtask

  // Cycles observed until done, counting from k0; 0 on budget expiry.
  task automatic wait_done(input int k0, input int budget, output int k);
    k = k0;
    while (done !== 1'b1 && k < budget) begin cyc(); k++; end
    if (done !== 1'b1) begin check("done_timeout", 32'(done), 32'd1); k = 0; end
  endtask

  task automatic wait_idle(input int budget, output int k);
    k = 0;
    while (busy !== 1'b0 && k < budget) begin cyc(); k++; end
    if (busy !== 1'b0) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  int k, bad;

  initial begin
    rst = 1'b0; start = 1'b0; addr = '0; poll_en = 1'b0;
    bus_gnt = 1'b1; DREQ = 1'b1; SO = 1'b0;
    repeat (3) cyc();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_XCS", 32'(XCS), 32'd1);
    check("reset_rdata", 32'(rdata), 32'd0);
    rst = 1'b1;
    repeat (2) cyc();

    // Single read of 0x0B with grant and DREQ already high.
    do_start(8'h0B);
    wait_done(1, 100, k);
    check("single_latency", 32'(k), 32'd36);
    check("single_rdata", 32'(rdata), 32'h2020);
    check("single_cmd", 32'(last_cmd), 32'h030B);
    check("single_dt", 32'(decode_time), 32'h0);
    wait_idle(20, k);
    check("single_gap", 32'(k), 32'd8);

    // Arbitration: no pin activity until the grant arrives.
    bus_gnt = 1'b0;
    do_start(8'h21);
    bad = 0;
    repeat (50) begin
      if (bus_req !== 1'b1 || XCS !== 1'b1 || SCK !== 1'b0) bad++;
      cyc();
    end
    check("arb_held", 32'(bad), 32'd0);
    bus_gnt = 1'b1;
    wait_done(0, 100, k);
    check("arb_latency", 32'(k), 32'd35);
    check("arb_rdata", 32'(rdata), 32'h21A5);
    wait_idle(20, k);

    // DREQ timeout.
    DREQ = 1'b0;
    do_start(8'h11);
    k = 1; bad = 0;
    while (err !== 1'b1 && k < 60) begin
      if (XCS !== 1'b1) bad++;
      cyc(); k++;
    end
    check("to_edge", 32'(k), 32'd22);
    check("to_bus_req", 32'(bus_req), 32'd0);
    check("to_xcs_low", 32'(bad), 32'd0);
    DREQ = 1'b1;
    wait_idle(20, k);
    check("to_gap", 32'(k), 32'd8);
    check("to_rdata_kept", 32'(rdata), 32'h21A5);

    // Automatic polling of SCI_DECODE_TIME.
    poll_en = 1'b1;
    wait_done(0, 300, k);
    check("poll1_dt", 32'(decode_time), 32'h0005);
    cyc();
    wait_done(1, 300, k);
    check("poll_period", 32'(k), 32'd100);
    check("poll2_dt", 32'(decode_time), 32'h0006);
    poll_en = 1'b0;
    wait_idle(20, k);
    repeat (2) cyc();

    // Collision: start on the same edge as a poll tick.
    poll_en = 1'b1;
    repeat (99) cyc();
    do_start(8'h0B);
    wait_done(1, 100, k);
    check("coll_first", 32'(rdata), 32'h2020);
    cyc();
    wait_done(1, 100, k);
    check("coll_spacing", 32'(k), 32'd44);
    check("coll_rdata", 32'(rdata), 32'h0007);
    check("coll_dt", 32'(decode_time), 32'h0007);
    poll_en = 1'b0;
    wait_idle(20, k);
    repeat (2) cyc();

    // Reset during pulse 10 of SHIFT.
    do_start(8'h0B);
    repeat (12) cyc();
    check("pre_rst_XCS", 32'(XCS), 32'd0);
    rst = 1'b0;
    cyc();
    check("rst_XCS", 32'(XCS), 32'd1);
    check("rst_SCK", 32'(SCK), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    rst = 1'b1;
    repeat (3) cyc();

    // Recovery read after reset.
    do_start(8'h0B);
    wait_done(1, 100, k);
    check("recov_latency", 32'(k), 32'd36);
    check("recov_rdata", 32'(rdata), 32'h2020);
    wait_idle(20, k);
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vs_sci_reader.md
# vs_sci_reader

SCI read controller for the VS10xx MP3 decoder. It issues SCI READ transactions (opcode 0x03) and captures the 16-bit register value returned on SO. It also polls SCI_DECODE_TIME on a fixed interval, so game logic can lock note timing to actual playback. It shares XCS/SCK/SI with the SCI/SDI write driver through a request/grant handshake, and drives those pins only while granted.

## Interface
- POLL_DIV, 32'd12288: clk cycles between automatic polls.
- POLL_ADDR, 8'h04: register read by automatic polls (SCI_DECODE_TIME).
- DREQ_TIMEOUT, 32'd65535: maximum clk cycles to wait for DREQ before aborting.
- GAP, 8'd8: minimum clk cycles XCS stays high after a transaction.
- clk  in  1  decoder clock (12.288 MHz / 6); the same clock as the write driver.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request for a single read; sampled only in IDLE.
- addr  in  8  SCI register address for start; latched on acceptance.
- poll_en  in  1  enables automatic polling.
- busy  out  1  high from acceptance until return to IDLE.
- done  out  1  one-cycle pulse when rdata is valid.
- err  out  1  one-cycle pulse on DREQ timeout.
- rdata  out  16  last value read.
- decode_time  out  16  last value read from POLL_ADDR.
- bus_req  out  1  request for the shared SCI pins.
- bus_gnt  in  1  grant from the arbiter/write driver.
- DREQ  in  1  decoder ready.
- SO  in  1  decoder serial out.
- XCS  out  1  SCI chip select, active low.
- SCK  out  1  serial clock; equals clk & sck_en.
- SI  out  1  serial data to the decoder.

## Operation
- All state, XCS, SI and sck_en update on the falling edge of clk. SO is registered on the rising edge of clk into so_q. The decoder samples SI on the rising edge of SCK and shifts SO on the falling edge of SCK.
- Reset (rst=0 at a falling edge) forces the following on that edge, regardless of state:
  - state=IDLE, XCS=1, SI=0, sck_en=0;
  - busy=0, done=0, err=0, bus_req=0;
  - rdata=0, decode_time=0;
  - poll counter=0, pending=0.
- Poll counter: increments while poll_en=1. When it reaches POLL_DIV-1 it wraps to 0 and sets pending. It clears to 0 while poll_en=0, and pending also clears then.
- IDLE:
  - If start=1: latch addr and go to REQ.
  - Else if pending=1: latch POLL_ADDR, clear pending, go to REQ.
  - start wins over a simultaneous poll tick; pending is retained and served afterwards.
- REQ: bus_req=1. When bus_gnt=1, go to WAIT_DREQ with the timeout counter set to 0.
- WAIT_DREQ:
  - DREQ=1: load shift register with {8'h03, addr, 16'h0000}, set bit counter to 32, go to SHIFT.
  - If the counter reaches DREQ_TIMEOUT: pulse err, drop bus_req, go to GAPW.
- SHIFT: XCS=0, sck_en=1. Each falling edge drives SI = sreg[31] and shifts left, for 32 SCK pulses.
  - Pulses 1..16 send the opcode and address MSB first.
  - For pulses 17..32, SI=0 and so_q is shifted into rdata_sh, MSB first. The shift uses so_q captured at that pulse's rising edge.
  - DREQ is ignored once SHIFT has started.
- After pulse 32 (DONE):
  - XCS=1, sck_en=0, SI=0.
  - rdata is loaded from rdata_sh and done pulses.
  - decode_time is loaded too if the latched address equals POLL_ADDR.
  - bus_req drops; go to GAPW.
- GAPW: holds for GAP cycles, then returns to IDLE with busy=0.
- bus_gnt falling during SHIFT is a protocol violation by the arbiter. The block still completes the transaction.

## Timing
- SCK is active for exactly 32 clk periods per read, with no gaps. XCS is low for exactly 32 falling edges.
- XCS falls on the same falling edge that drives opcode bit 7. It rises on the edge after pulse 32.
- Latency, start to done, with bus_gnt and DREQ already high: 1 (IDLE→REQ) + 1 (REQ→WAIT_DREQ) + 1 (WAIT_DREQ→SHIFT) + 32 + 1 = 36 falling edges.
- done and err are each exactly one cycle and are mutually exclusive. busy=1 in every state except IDLE.
- Poll period is POLL_DIV cycles. Ticks arriving while one is already pending merge into one.

## Test plan
- Single read: start with addr=0x0B; the decoder model returns 0x2020. Required:
  - SI carries 0x030B on pulses 1–16;
  - rdata=0x2020 and done=1 at edge 36;
  - decode_time unchanged.
- Poll: POLL_DIV=100 and poll_en=1; the model returns 0x0005, then 0x0006. Required: read addr 0x04 every 100 cycles, and decode_time=0x0005, then 0x0006.
- Arbitration: hold bus_gnt=0 for 50 cycles after start. Required: bus_req=1, XCS=1 and SCK idle throughout; the transaction begins the cycle after the grant.
- DREQ timeout: DREQ_TIMEOUT=20 and DREQ=0. Required: err pulse after 20 cycles in WAIT_DREQ, bus_req=0, XCS never low, then IDLE.
- Collision: start with addr=0x0B in the same cycle as a poll tick. Required: read 0x0B first, then 0x04 after GAP, and rdata ends at the 0x04 value.
- Reset: rst=0 at pulse 10 of SHIFT. Required: on the next falling edge XCS=1, SCK=0, bus_req=0, busy=0, and rdata=0.
